// File: rtl/serial_idft_pkg.sv
// Shared types and sample formatting for the serial inverse-DFT synthesizer.
// SERIAL_IDFT_SAT_EN selects saturation; otherwise samples wrap to Y_WIDTH bits.
package serial_idft_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int SUM_MAX_W = 128;

    function automatic logic signed [SUM_MAX_W-1:0] fmt_sample(
        input logic signed [SUM_MAX_W-1:0] sum,
        input int                          shift,
        input int                          y_width
    );
        logic signed [SUM_MAX_W-1:0] shifted;
        logic signed [SUM_MAX_W-1:0] max_v;
        logic signed [SUM_MAX_W-1:0] min_v;
        shifted = sum >>> shift;
`ifdef SERIAL_IDFT_SAT_EN
        max_v = 128'sd1 <<< (y_width - 1);
        max_v = max_v - 128'sd1;
        min_v = -max_v - 128'sd1;
        if (shifted > max_v) begin
            fmt_sample = max_v;
        end else if (shifted < min_v) begin
            fmt_sample = min_v;
        end else begin
            fmt_sample = shifted;
        end
`else
        // Sign-extend from bit y_width-1 so the caller's truncation is a pure wrap.
        max_v = shifted <<< (SUM_MAX_W - y_width);
        min_v = max_v >>> (SUM_MAX_W - y_width);
        fmt_sample = min_v;
`endif
    endfunction

endpackage

// File: rtl/idft_cmul_re.sv
// Real part of one complex product re*w_re - im*w_im, scaled and formatted to Y_WIDTH.
module idft_cmul_re
    import serial_idft_pkg::*;
#(
    parameter int W_WIDTH = 16,
    parameter int S_WIDTH = 32,
    parameter int Y_WIDTH = 16,
    parameter int SHIFT   = 14
) (
    input  logic signed [S_WIDTH-1:0] re_i,
    input  logic signed [S_WIDTH-1:0] im_i,
    input  logic signed [W_WIDTH-1:0] w_re_i,
    input  logic signed [W_WIDTH-1:0] w_im_i,
    output logic signed [Y_WIDTH-1:0] y_o
);

    localparam int P_W = W_WIDTH + S_WIDTH;
    localparam int D_W = P_W + 1;

    logic signed [P_W-1:0]       re_ext_s;
    logic signed [P_W-1:0]       im_ext_s;
    logic signed [P_W-1:0]       wr_ext_s;
    logic signed [P_W-1:0]       wi_ext_s;
    logic signed [P_W-1:0]       prod_re_s;
    logic signed [P_W-1:0]       prod_im_s;
    logic signed [D_W-1:0]       diff_s;
    logic signed [SUM_MAX_W-1:0] sum_ext_s;

    // Full-width products, one-bit-wider difference, then shift and format.
    always_comb begin
        re_ext_s  = {{W_WIDTH{re_i[S_WIDTH-1]}}, re_i};
        im_ext_s  = {{W_WIDTH{im_i[S_WIDTH-1]}}, im_i};
        wr_ext_s  = {{S_WIDTH{w_re_i[W_WIDTH-1]}}, w_re_i};
        wi_ext_s  = {{S_WIDTH{w_im_i[W_WIDTH-1]}}, w_im_i};
        prod_re_s = re_ext_s * wr_ext_s;
        prod_im_s = im_ext_s * wi_ext_s;
        diff_s    = {prod_re_s[P_W-1], prod_re_s} - {prod_im_s[P_W-1], prod_im_s};
        sum_ext_s = {{(SUM_MAX_W-D_W){diff_s[D_W-1]}}, diff_s};
        y_o       = Y_WIDTH'(fmt_sample(sum_ext_s, SHIFT, Y_WIDTH));
    end

endmodule

// File: rtl/serial_idft_coral.sv
// Serial single-bin inverse DFT: latches one complex coefficient per channel and
// streams FRAME_LENGTH real samples. Saturation enabled by SERIAL_IDFT_SAT_EN.
module serial_idft_coral
    import serial_idft_pkg::*;
#(
    parameter int W_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int Y_WIDTH      = 16,
    parameter int SHIFT        = 14,
    parameter int FRAME_LENGTH = 3,
    parameter int CHANELS      = 2
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     valid_i,
    output logic                                     ready_o,
    input  logic signed [CHANELS-1:0][S_WIDTH-1:0]   re,
    input  logic signed [CHANELS-1:0][S_WIDTH-1:0]   im,
    output logic [$clog2(FRAME_LENGTH)-1:0]          counter,
    input  logic signed [W_WIDTH-1:0]                w_re,
    input  logic signed [W_WIDTH-1:0]                w_im,
    output logic signed [CHANELS-1:0][Y_WIDTH-1:0]   y,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic                                     last_o
);

    localparam int CW = $clog2(FRAME_LENGTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LENGTH - 1);

    state_e                              state_q, state_d;
    logic [CW-1:0]                       counter_q, counter_d;
    logic [CHANELS-1:0][S_WIDTH-1:0]     re_q, re_d;
    logic [CHANELS-1:0][S_WIDTH-1:0]     im_q, im_d;
    logic [CHANELS-1:0][Y_WIDTH-1:0]     y_q, y_d;
    logic                                valid_q, valid_d;
    logic                                last_q, last_d;
    logic [CHANELS-1:0][Y_WIDTH-1:0]     ymul_s;
    logic                                load_s;

    for (genvar c = 0; c < CHANELS; c++) begin : g_ch
        idft_cmul_re #(
            .W_WIDTH (W_WIDTH),
            .S_WIDTH (S_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .SHIFT   (SHIFT)
        ) u_cmul (
            .re_i   (re_q[c]),
            .im_i   (im_q[c]),
            .w_re_i (w_re),
            .w_im_i (w_im),
            .y_o    (ymul_s[c])
        );
    end

    // State, counter, coefficient and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            counter_q <= '0;
            re_q      <= '0;
            im_q      <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            re_q      <= re_d;
            im_q      <= im_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    // Next-state: accept in IDLE, emit one sample per load in RUN.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        re_d      = re_q;
        im_d      = im_q;
        y_d       = y_q;
        valid_d   = valid_q;
        last_d    = last_q;
        load_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    re_d    = re;
                    im_d    = im;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                load_s = !valid_q || ready_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_s) begin
            y_d     = ymul_s;
            valid_d = 1'b1;
            last_d  = (counter_q == LAST_IDX);
            if (counter_q == LAST_IDX) begin
                counter_d = '0;
                state_d   = IDLE;
            end else begin
                counter_d = counter_q + CW'(1);
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Outputs: ready_o depends on state only, everything else straight from flops.
    always_comb begin
        ready_o = (state_q == IDLE);
        counter = counter_q;
        y       = y_q;
        valid_o = valid_q;
        last_o  = last_q;
    end

endmodule

// File: tb/tb_serial_idft_coral.sv
// Scoreboard bench for serial_idft_coral with FRAME_LENGTH=4 and a quarter-wave ROM.
module tb_serial_idft_coral;

    localparam int W_WIDTH = 16;
    localparam int S_WIDTH = 32;
    localparam int Y_WIDTH = 16;
    localparam int FL      = 4;
    localparam int CH      = 2;

    typedef struct {
        logic signed [Y_WIDTH-1:0] y0;
        logic signed [Y_WIDTH-1:0] y1;
        logic                      last;
    } exp_t;

    logic                              clk = 1'b0;
    logic                              rstn;
    logic                              valid_i;
    logic                              ready_o;
    logic signed [CH-1:0][S_WIDTH-1:0] re_s;
    logic signed [CH-1:0][S_WIDTH-1:0] im_s;
    logic [1:0]                        counter;
    logic signed [W_WIDTH-1:0]         w_re;
    logic signed [W_WIDTH-1:0]         w_im;
    logic signed [CH-1:0][Y_WIDTH-1:0] y;
    logic                              valid_o;
    logic                              ready_i;
    logic                              last_o;

    logic signed [W_WIDTH-1:0] rom_re [FL] = '{16'sd16384, 16'sd0, -16'sd16384, 16'sd0};
    logic signed [W_WIDTH-1:0] rom_im [FL] = '{16'sd0, 16'sd16384, 16'sd0, -16'sd16384};

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    serial_idft_coral #(
        .W_WIDTH      (W_WIDTH),
        .S_WIDTH      (S_WIDTH),
        .Y_WIDTH      (Y_WIDTH),
        .SHIFT        (14),
        .FRAME_LENGTH (FL),
        .CHANELS      (CH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .re      (re_s),
        .im      (im_s),
        .counter (counter),
        .w_re    (w_re),
        .w_im    (w_im),
        .y       (y),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o)
    );

    always #5 clk = ~clk;

    // Combinational twiddle ROM addressed by the DUT counter.
    always_comb begin
        w_re = rom_re[counter];
        w_im = rom_im[counter];
    end

    // Monitor: every accepted output sample is popped and compared.
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_sample: got y0=%0d y1=%0d last=%0b, required no sample",
                         $signed(y[0]), $signed(y[1]), last_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (y[0] !== e.y0 || y[1] !== e.y1 || last_o !== e.last) begin
                    n_err++;
                    $display("FAIL sample: got y0=%0d y1=%0d last=%0b, required y0=%0d y1=%0d last=%0b",
                             $signed(y[0]), $signed(y[1]), last_o, e.y0, e.y1, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int y0, input int y1, input logic last);
        exp_t e;
        e.y0   = Y_WIDTH'(y0);
        e.y1   = Y_WIDTH'(y1);
        e.last = last;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3);
        push(a0, b0, 1'b0);
        push(a1, b1, 1'b0);
        push(a2, b2, 1'b0);
        push(a3, b3, 1'b1);
    endtask

    // Drive a coefficient set and return #1 after the accepting edge.
    task automatic send(input logic signed [31:0] r0, input logic signed [31:0] r1,
                        input logic signed [31:0] i0, input logic signed [31:0] i1,
                        input bit hold);
        int guard;
        re_s[0] = r0;
        re_s[1] = r1;
        im_s[0] = i0;
        im_s[1] = i1;
        valid_i = 1'b1;
        guard   = 0;
        while (!ready_o && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) check("send_ready_timeout", 64'sd0, 64'sd1);
        @(posedge clk);
        #1;
        if (!hold) valid_i = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || valid_o) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_queue_empty", sb_q.size(), 64'sd0);
    endtask

    initial begin
        rstn    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        re_s    = '0;
        im_s    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_o", ready_o, 64'sd1);
        check("rst_valid_o", valid_o, 64'sd0);
        check("rst_last_o", last_o, 64'sd0);
        check("rst_counter", counter, 64'sd0);
        check("rst_y0", $signed(y[0]), 64'sd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic real, including first-sample latency and consecutive output cycles.
        push_frame(100, 0, -100, 0, -7, 0, 7, 0);
        send(32'sd100, -32'sd7, 32'sd0, 32'sd0, 1'b0);
        check("real_ready_low_in_run", ready_o, 64'sd0);
        @(negedge clk);
        check("real_no_sample_before_e1", valid_o, 64'sd0);
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            check("real_consecutive_valid", valid_o, 64'sd1);
            check("real_last_flag", last_o, (k == FL - 1) ? 64'sd1 : 64'sd0);
        end
        @(negedge clk);
        check("real_valid_clears", valid_o, 64'sd0);
        check("real_ready_back", ready_o, 64'sd1);
        drain();

        // Basic imaginary.
        push_frame(0, -50, 0, 50, 0, 0, 0, 0);
        send(32'sd0, 32'sd0, 32'sd50, 32'sd0, 1'b0);
        drain();

        // Backpressure while sample 1 is presented.
        push_frame(100, 0, -100, 0, -7, 0, 7, 0);
        send(32'sd100, -32'sd7, 32'sd0, 32'sd0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_counter_hold", counter, 64'sd2);
            check("bp_y0_hold", $signed(y[0]), 64'sd0);
            check("bp_valid_hold", valid_o, 64'sd1);
        end
        ready_i = 1'b1;
        drain();

        // Saturation versus wrap on a large coefficient.
`ifdef SERIAL_IDFT_SAT_EN
        push_frame(32767, 0, -32768, 0, 3, 0, -3, 0);
`else
        push_frame(0, 0, 0, 0, 3, 0, -3, 0);
`endif
        send(32'sd1048576, 32'sd3, 32'sd0, 32'sd0, 1'b0);
        drain();

        // Back-to-back with valid_i held high through RUN.
        push_frame(5, 0, -5, 0, 6, 0, -6, 0);
        push_frame(0, -9, 0, 9, 0, 2, 0, -2);
        send(32'sd5, 32'sd6, 32'sd0, 32'sd0, 1'b1);
        send(32'sd0, 32'sd0, 32'sd9, -32'sd2, 1'b1);
        check("b2b_gap_cycle", valid_o, 64'sd0);
        re_s[0] = 32'sd777;
        im_s[0] = 32'sd777;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        drain();

        // Mid-frame reset after sample 1.
        push(11, 22, 1'b0);
        push(0, 0, 1'b0);
        send(32'sd11, 32'sd22, 32'sd0, 32'sd0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_valid_o", valid_o, 64'sd0);
        check("mrst_y0", $signed(y[0]), 64'sd0);
        check("mrst_y1", $signed(y[1]), 64'sd0);
        check("mrst_counter", counter, 64'sd0);
        check("mrst_ready_o", ready_o, 64'sd1);
        rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mrst_queue_empty", sb_q.size(), 64'sd0);
        check("mrst_no_valid", valid_o, 64'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_idft_coral.md
# serial_idft_coral

Serial inverse-DFT synthesizer for a single frequency bin, multichannel. It accepts one complex bin coefficient per channel and streams FRAME_LENGTH real time-domain samples per channel, y[n] = Re(X·w[n]). It is the transmit-side counterpart of the serial single-bin DFT accumulator. It drives the same external twiddle ROM index and input port scheme: counter out, w_re/w_im in.

## Interface
- W_WIDTH, 16, twiddle component width (signed)
- S_WIDTH, 32, bin coefficient component width (signed)
- Y_WIDTH, 16, output sample width (signed)
- SHIFT, 14, arithmetic right shift applied to each product sum
- FRAME_LENGTH, 3, samples per frame; must be ≥ 2
- CHANELS, 2, parallel channels sharing one twiddle
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- valid_i  in  1  coefficient set valid
- ready_o  out  1  block can accept a coefficient set
- re  in  [CHANELS][S_WIDTH] signed  bin real part per channel
- im  in  [CHANELS][S_WIDTH] signed  bin imaginary part per channel
- counter  out  $clog2(FRAME_LENGTH)  twiddle ROM index for the next sample
- w_re  in  W_WIDTH signed  twiddle real part for index counter, same cycle (combinational ROM)
- w_im  in  W_WIDTH signed  twiddle imaginary part
- y  out  [CHANELS][Y_WIDTH] signed  output samples
- valid_o  out  1  y valid
- ready_i  in  1  downstream accepts y
- last_o  out  1  y is sample FRAME_LENGTH-1 of the frame

## Operation
- States: IDLE, RUN.
- IDLE:
  - ready_o=1, counter=0.
  - On valid_i: latch re/im for all channels, go to RUN.
- RUN:
  - ready_o=0; valid_i is ignored and the latched coefficients are unchanged.
  - load = !valid_o || ready_i.
  - On load: y[c] ← fmt(re[c]·w_re − im[c]·w_im), valid_o ← 1, last_o ← (counter==FRAME_LENGTH-1).
  - Also on load: counter increments, or wraps to 0 and the state returns to IDLE when it was FRAME_LENGTH-1.
- Outside RUN: valid_o clears when valid_o && ready_i and there is no load.
- Output stall: while valid_o && !ready_i, y, last_o and counter hold.
- A new frame may be accepted while the previous last sample is still stalled. Its first load waits on the same load rule.
- Arithmetic:
  - Products are full width, W_WIDTH+S_WIDTH.
  - The difference is W_WIDTH+S_WIDTH+1 bits.
  - It is then arithmetically shifted right by SHIFT (floor), then reduced to Y_WIDTH per Configuration.
- Reset values: ready_o=1 (IDLE), counter=0, y=0, valid_o=0, last_o=0, coefficient registers=0.
- Reset asserted mid-frame aborts the frame. No further samples from that frame are emitted.

## Timing
- The coefficient handshake occurs at edge E0. The first sample appears on y/valid_o after edge E1.
- Without backpressure, samples appear on consecutive cycles. last_o is high with sample FRAME_LENGTH-1.
- ready_o rises in the cycle after the last load. Sustained throughput is FRAME_LENGTH samples per FRAME_LENGTH+1 cycles.
- counter changes only on load, or to 0 on reset. w_re/w_im must be stable and combinationally valid from counter within the cycle.
- No combinational path from ready_i or valid_i to ready_o. ready_o is a function of state only.

## Configuration
- SERIAL_IDFT_SAT_EN defined: the shifted sum saturates to [−2^(Y_WIDTH−1), 2^(Y_WIDTH−1)−1].
- SERIAL_IDFT_SAT_EN undefined: the shifted sum is truncated to its low Y_WIDTH bits (two's-complement wrap).
- All other behaviour is identical.

## Structure
- Package serial_idft_pkg holds:
  - state enum (IDLE, RUN)
  - function fmt_sample(sum, SHIFT, Y_WIDTH), with the saturate/wrap selected by the macro
- Sub-module idft_cmul_re, one instance per channel via generate. It computes the combinational re·w_re − im·w_im, shift and format.
- The top module holds the FSM, counter, coefficient registers and output register.

## Test plan
Config for all scenarios: FRAME_LENGTH=4, SHIFT=14, CHANELS=2. ROM w_re=[16384,0,−16384,0], w_im=[0,16384,0,−16384].
- Basic real: re=[100,−7], im=0 -> ch0 y=100,0,−100,0 and ch1 y=−7,0,7,0 on 4 consecutive cycles after E1; last_o only on the 4th sample.
- Basic imaginary: re=0, im=[50,0] -> ch0 y=0,−50,0,50, ch1 all 0.
- Backpressure: ready_i low for 3 cycles while sample 1 is presented -> y holds at 0 (ch0 of the real case); counter holds at 2; no sample is lost or duplicated.
- Saturation: re=2^20, im=0, sample 0 -> y=32767 with SERIAL_IDFT_SAT_EN; y=0 without it.
- Back-to-back: valid_i held high, two distinct sets -> 4 samples, a 1-cycle gap, then 4 samples of the second set; valid_i is ignored during RUN.
- Mid-frame reset: rstn low for 1 cycle after sample 1 -> next cycle valid_o=0, y=0, counter=0, ready_o=1; no remaining samples of that frame appear.
